// File: rtl/fpu_pkg.sv
// Shared FP definitions: rounding-mode encodings, flag positions, double
// field layout and integer saturation constants.
package fpu_pkg;

    localparam int unsigned FP_W     = 64;
    localparam int unsigned EXP_W    = 11;
    localparam int unsigned MAN_W    = 52;
    localparam int unsigned SIG_W    = MAN_W + 1;
    localparam int unsigned INT_W    = 64;
    localparam int unsigned EXP_BIAS = 1023;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int unsigned FLG_W  = 5;
    localparam int unsigned FLG_NV = 4;
    localparam int unsigned FLG_DZ = 3;
    localparam int unsigned FLG_OF = 2;
    localparam int unsigned FLG_UF = 1;
    localparam int unsigned FLG_NX = 0;

    localparam logic [INT_W-1:0] INT64_MAX  = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [INT_W-1:0] INT64_MIN  = 64'h8000_0000_0000_0000;
    localparam logic [INT_W-1:0] UINT64_MAX = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp64_t;

endpackage

// File: rtl/fcvt_round_inc.sv
// Rounding increment decision for a magnitude with guard/sticky bits.
module fcvt_round_inc
    import fpu_pkg::*;
(
    input  logic [2:0] rm,
    input  logic       sign,
    input  logic       lsb,
    input  logic       guard,
    input  logic       sticky,
    output logic       inc
);

    logic w_inexact;

    // Directed modes act on magnitude, so the sign flips RDN/RUP direction.
    always_comb begin
        w_inexact = guard | sticky;
        inc       = 1'b0;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & w_inexact;
            RM_RUP:  inc = ~sign & w_inexact;
            RM_RMM:  inc = guard;
            default: inc = guard & (sticky | lsb);
        endcase
    end

endmodule

// File: rtl/fcvt_int.sv
// Double to 64-bit integer converter, IDLE/ALIGN/ROUND/DONE sequencer.
// Optional unsigned conversion enabled by defining FCVT_UNSIGNED_EN.
module fcvt_int
    import fpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
`ifdef FCVT_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_fp,
    input  logic [2:0]       rm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_int,
    output logic [FLG_W-1:0] out_flags
);

    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_ROUND, S_DONE} state_t;

    state_t             r_state, nx_state;
    logic               r_sign, nx_sign;
    logic [MAN_W-1:0]   r_man, nx_man;
    logic [2:0]         r_rm, nx_rm;
    logic signed [12:0] r_exp, nx_exp;
    logic               r_zero, nx_zero;
    logic               r_sub, nx_sub;
    logic               r_inf, nx_inf;
    logic               r_nan, nx_nan;
    logic               r_uns, nx_uns;
    logic [INT_W-1:0]   r_mag, nx_mag;
    logic               r_grd, nx_grd;
    logic               r_stk, nx_stk;
    logic               r_big, nx_big;
    logic [INT_W-1:0]   r_res, nx_res;
    logic [FLG_W-1:0]   r_flg, nx_flg;
    logic               r_in_ready, nx_in_ready;
    logic               r_out_valid, nx_out_valid;
    logic [INT_W-1:0]   r_out_int, nx_out_int;
    logic [FLG_W-1:0]   r_out_flags, nx_out_flags;

    fp64_t              w_fp;
    logic               w_is_uns;
    logic [SIG_W-1:0]   w_sig;
    logic [6:0]         w_amt;
    logic [127:0]       w_sh;
    logic               w_inc;
    logic [INT_W:0]     w_rmag;
    logic               w_nx;

    assign w_fp = in_fp;

`ifdef FCVT_UNSIGNED_EN
    assign w_is_uns = is_unsigned;
`else
    assign w_is_uns = 1'b0;
`endif

    // Significand placed at the top of a 64.64 fixed-point window, then
    // shifted right so the integer part lands in [127:64].
    assign w_sig  = {~(r_zero | r_sub), r_man};
    assign w_amt  = 7'(13'sd63 - r_exp);
    assign w_sh   = {w_sig, 75'd0} >> w_amt;

    assign w_rmag = {1'b0, r_mag} + (INT_W+1)'(w_inc);
    assign w_nx   = r_grd | r_stk;

    fcvt_round_inc u_round_inc (
        .rm     (r_rm),
        .sign   (r_sign),
        .lsb    (r_mag[0]),
        .guard  (r_grd),
        .sticky (r_stk),
        .inc    (w_inc)
    );

    // Next-state and next register values for every stage.
    always_comb begin
        nx_state     = r_state;
        nx_sign      = r_sign;
        nx_man       = r_man;
        nx_rm        = r_rm;
        nx_exp       = r_exp;
        nx_zero      = r_zero;
        nx_sub       = r_sub;
        nx_inf       = r_inf;
        nx_nan       = r_nan;
        nx_uns       = r_uns;
        nx_mag       = r_mag;
        nx_grd       = r_grd;
        nx_stk       = r_stk;
        nx_big       = r_big;
        nx_res       = r_res;
        nx_flg       = r_flg;
        nx_out_valid = r_out_valid;
        nx_out_int   = r_out_int;
        nx_out_flags = r_out_flags;

        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    nx_sign  = w_fp.sign;
                    nx_man   = w_fp.man;
                    nx_rm    = rm;
                    nx_uns   = w_is_uns;
                    nx_exp   = $signed({2'b00, w_fp.exp}) - 13'(EXP_BIAS);
                    nx_zero  = (w_fp.exp == '0) && (w_fp.man == '0);
                    nx_sub   = (w_fp.exp == '0) && (w_fp.man != '0);
                    nx_inf   = (w_fp.exp == '1) && (w_fp.man == '0);
                    nx_nan   = (w_fp.exp == '1) && (w_fp.man != '0);
                    nx_state = S_ALIGN;
                end
            end

            S_ALIGN: begin
                if (r_exp > 13'sd63) begin
                    nx_big = 1'b1;
                    nx_mag = '0;
                    nx_grd = 1'b0;
                    nx_stk = 1'b0;
                end else if (r_exp < -13'sd1) begin
                    nx_big = 1'b0;
                    nx_mag = '0;
                    nx_grd = 1'b0;
                    nx_stk = |w_sig;
                end else begin
                    nx_big = 1'b0;
                    nx_mag = w_sh[127:64];
                    nx_grd = w_sh[63];
                    nx_stk = |w_sh[62:0];
                end
                nx_state = S_ROUND;
            end

            S_ROUND: begin
                nx_flg = '0;
                if (r_uns) begin
                    if (r_nan || ((r_inf || r_big) && !r_sign)) begin
                        nx_res = UINT64_MAX;
                        nx_flg[FLG_NV] = 1'b1;
                    end else if (r_inf || r_big) begin
                        nx_res = '0;
                        nx_flg[FLG_NV] = 1'b1;
                    end else if (r_zero) begin
                        nx_res = '0;
                    end else if (!r_sign) begin
                        if (w_rmag[INT_W]) begin
                            nx_res = UINT64_MAX;
                            nx_flg[FLG_NV] = 1'b1;
                        end else begin
                            nx_res = w_rmag[INT_W-1:0];
                            nx_flg[FLG_NX] = w_nx;
                        end
                    end else if (w_rmag != '0) begin
                        nx_res = '0;
                        nx_flg[FLG_NV] = 1'b1;
                    end else begin
                        nx_res = '0;
                        nx_flg[FLG_NX] = w_nx;
                    end
                end else begin
                    if (r_nan || ((r_inf || r_big) && !r_sign)) begin
                        nx_res = INT64_MAX;
                        nx_flg[FLG_NV] = 1'b1;
                    end else if (r_inf || r_big) begin
                        nx_res = INT64_MIN;
                        nx_flg[FLG_NV] = 1'b1;
                    end else if (r_zero) begin
                        nx_res = '0;
                    end else if (!r_sign) begin
                        if (w_rmag > {1'b0, INT64_MAX}) begin
                            nx_res = INT64_MAX;
                            nx_flg[FLG_NV] = 1'b1;
                        end else begin
                            nx_res = w_rmag[INT_W-1:0];
                            nx_flg[FLG_NX] = w_nx;
                        end
                    end else begin
                        if (w_rmag > {1'b0, INT64_MIN}) begin
                            nx_res = INT64_MIN;
                            nx_flg[FLG_NV] = 1'b1;
                        end else begin
                            nx_res = (~w_rmag[INT_W-1:0]) + 64'd1;
                            nx_flg[FLG_NX] = w_nx;
                        end
                    end
                end
                nx_state = S_DONE;
            end

            S_DONE: begin
                // First DONE cycle loads the output registers; they then hold
                // until the consumer takes them.
                if (r_out_valid && out_ready) begin
                    nx_out_valid = 1'b0;
                    nx_state     = S_IDLE;
                end else begin
                    nx_out_valid = 1'b1;
                    nx_out_int   = r_res;
                    nx_out_flags = r_flg;
                end
            end

            default: nx_state = S_IDLE;
        endcase

        nx_in_ready = (nx_state == S_IDLE);
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sign      <= 1'b0;
            r_man       <= '0;
            r_rm        <= '0;
            r_exp       <= '0;
            r_zero      <= 1'b0;
            r_sub       <= 1'b0;
            r_inf       <= 1'b0;
            r_nan       <= 1'b0;
            r_uns       <= 1'b0;
            r_mag       <= '0;
            r_grd       <= 1'b0;
            r_stk       <= 1'b0;
            r_big       <= 1'b0;
            r_res       <= '0;
            r_flg       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_int   <= '0;
            r_out_flags <= '0;
        end else begin
            r_state     <= nx_state;
            r_sign      <= nx_sign;
            r_man       <= nx_man;
            r_rm        <= nx_rm;
            r_exp       <= nx_exp;
            r_zero      <= nx_zero;
            r_sub       <= nx_sub;
            r_inf       <= nx_inf;
            r_nan       <= nx_nan;
            r_uns       <= nx_uns;
            r_mag       <= nx_mag;
            r_grd       <= nx_grd;
            r_stk       <= nx_stk;
            r_big       <= nx_big;
            r_res       <= nx_res;
            r_flg       <= nx_flg;
            r_in_ready  <= nx_in_ready;
            r_out_valid <= nx_out_valid;
            r_out_int   <= nx_out_int;
            r_out_flags <= nx_out_flags;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_int   = r_out_int;
    assign out_flags = r_out_flags;

endmodule

// File: tb/tb_fcvt_int.sv
// Bench for fcvt_int: scoreboard of expected results checked as outputs are
// consumed, plus latency, back-pressure and mid-conversion reset checks.
module tb_fcvt_int;

    localparam logic [4:0] F0 = 5'b00000;
    localparam logic [4:0] NV = 5'b10000;
    localparam logic [4:0] NX = 5'b00001;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_fp;
    logic [2:0]  rm;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_int;
    logic [4:0]  out_flags;
`ifdef FCVT_UNSIGNED_EN
    logic        is_uns;
`endif

    int chk_cnt  = 0;
    int fail_cnt = 0;

    logic [63:0] exp_int_q[$];
    logic [4:0]  exp_flg_q[$];
    string       tag_q[$];

    fcvt_int dut (
        .clk       (clk),
        .rst       (rst),
`ifdef FCVT_UNSIGNED_EN
        .is_unsigned (is_uns),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fp     (in_fp),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_int   (out_int),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got=0x%016h exp=0x%016h", tag, got, exp);
        end
    endtask

    // Pop and compare whenever the DUT hands a result to the consumer.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_int_q.size() == 0) begin
                check("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                string       t;
                logic [63:0] ei;
                logic [4:0]  ef;
                t  = tag_q.pop_front();
                ei = exp_int_q.pop_front();
                ef = exp_flg_q.pop_front();
                check({t, "_int"}, out_int, ei);
                check({t, "_flags"}, 64'(out_flags), 64'(ef));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("idle_timeout", 64'(in_ready), 64'd1);
    endtask

    // Drive one operation, queue its expectation and measure latency.
    task automatic send(input string tag, input logic [63:0] fp, input logic [2:0] mode,
                        input logic [63:0] e_int, input logic [4:0] e_flg);
        int n;
        wait_idle();
        @(negedge clk);
        tag_q.push_back(tag);
        exp_int_q.push_back(e_int);
        exp_flg_q.push_back(e_flg);
        in_fp    = fp;
        rm       = mode;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_fp     = '0;
        rm        = 3'b000;
        out_ready = 1'b1;
`ifdef FCVT_UNSIGNED_EN
        is_uns    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_int", out_int, 64'd0);
        check("rst_out_flags", 64'(out_flags), 64'd0);
        rst = 1'b0;

        send("p100_rtz",  64'h4059000000000000, 3'b001, 64'h64, F0);
        send("m2p5_rne",  64'hC004000000000000, 3'b000, 64'hFFFF_FFFF_FFFF_FFFE, NX);
        send("m2p5_rmm",  64'hC004000000000000, 3'b100, 64'hFFFF_FFFF_FFFF_FFFD, NX);
        send("m2p5_rdn",  64'hC004000000000000, 3'b010, 64'hFFFF_FFFF_FFFF_FFFD, NX);
        send("m2p5_rup",  64'hC004000000000000, 3'b011, 64'hFFFF_FFFF_FFFF_FFFE, NX);
        send("p2p5_rsv",  64'h4004000000000000, 3'b101, 64'h2, NX);
        send("p1p5_rne",  64'h3FF8000000000000, 3'b000, 64'h2, NX);
        send("p0p5_rne",  64'h3FE0000000000000, 3'b000, 64'h0, NX);
        send("p0p5_rmm",  64'h3FE0000000000000, 3'b100, 64'h1, NX);
        send("p2e63",     64'h43E0000000000000, 3'b000, 64'h7FFF_FFFF_FFFF_FFFF, NV);
        send("m2e63",     64'hC3E0000000000000, 3'b000, 64'h8000_0000_0000_0000, F0);
        send("p2e64",     64'h43F0000000000000, 3'b001, 64'h7FFF_FFFF_FFFF_FFFF, NV);
        send("max_below", 64'h43DFFFFFFFFFFFFF, 3'b000, 64'h7FFF_FFFF_FFFF_FC00, F0);
        send("qnan",      64'h7FF8000000000000, 3'b000, 64'h7FFF_FFFF_FFFF_FFFF, NV);
        send("pinf",      64'h7FF0000000000000, 3'b000, 64'h7FFF_FFFF_FFFF_FFFF, NV);
        send("minf",      64'hFFF0000000000000, 3'b000, 64'h8000_0000_0000_0000, NV);
        send("sub_rup",   64'h0000000000000001, 3'b011, 64'h1, NX);
        send("sub_rtz",   64'h0000000000000001, 3'b001, 64'h0, NX);
        send("nzero",     64'h8000000000000000, 3'b010, 64'h0, F0);
        send("pzero",     64'h0000000000000000, 3'b011, 64'h0, F0);

`ifdef FCVT_UNSIGNED_EN
        is_uns = 1'b1;
        send("u_m1",      64'hBFF0000000000000, 3'b000, 64'h0, NV);
        send("u_m0p25",   64'hBFD0000000000000, 3'b001, 64'h0, NX);
        send("u_p2e63",   64'h43E0000000000000, 3'b000, 64'h8000_0000_0000_0000, F0);
        send("u_p2e64",   64'h43F0000000000000, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, NV);
        send("u_minf",    64'hFFF0000000000000, 3'b000, 64'h0, NV);
        is_uns = 1'b0;
`endif

        // Back-pressure: result must hold while the consumer stalls.
        wait_idle();
        out_ready = 1'b0;
        send("stall", 64'h4059000000000000, 3'b001, 64'h64, F0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_int", out_int, 64'h64);
            check("stall_flags", 64'(out_flags), 64'd0);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;

        // Reset during ALIGN of the next operation must drop it entirely.
        wait_idle();
        @(negedge clk);
        in_fp    = 64'hC004000000000000;
        rm       = 3'b000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_int", out_int, 64'd0);
        check("abort_out_flags", 64'(out_flags), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_result", 64'(out_valid), 64'd0);
        end

        send("post_abort", 64'h3FF8000000000000, 3'b001, 64'h1, NX);

        n = 0;
        while (exp_int_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("sb_drained", 64'(exp_int_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/fcvt_int.md
FCVT_INT -- requirements
Module: fcvt_int

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset, ports as below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operand and rm valid.
REQ-005 in_ready  output  1  block idle and able to accept.
REQ-006 in_fp  input  64  IEEE-754 double operand {S, E[10:0], M[51:0]}.
REQ-007 rm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 out_int  output  64  two's-complement signed 64-bit result.
REQ-011 out_flags  output  5  {NV, DZ, OF, UF, NX}; DZ, OF and UF SHALL always be 0.

Function
REQ-012 FSM states SHALL be IDLE, ALIGN, ROUND, DONE; in_ready SHALL be 1 only in IDLE.
REQ-013 IDLE: on in_valid&in_ready, SHALL register in_fp, rm, sign, unbiased exponent e=E-1023 and class (zero, subnormal, inf, NaN), then go to ALIGN.
REQ-014 ALIGN: SHALL shift significand {1,M} (or {0,M} if E==0) to integer magnitude plus guard and sticky bits; e<0 yields magnitude 0 with guard and sticky from the whole significand; then go to ROUND.
REQ-015 ROUND: SHALL apply rm increment to magnitude, negate if S, saturate, compute flags, then go to DONE.
REQ-016 Latency: input accepted on edge k SHALL give out_valid=1 from edge k+3.
REQ-017 DONE: out_valid=1; out_int and out_flags SHALL be held stable until out_valid&out_ready, then the FSM SHALL return to IDLE.
REQ-018 Reserved rm (101-111) SHALL be treated as RNE.
REQ-019 NaN, +inf, or a rounded value >2^63-1 SHALL give 0x7FFF_FFFF_FFFF_FFFF with NV=1, NX=0.
REQ-020 -inf or a rounded value <-2^63 SHALL give 0x8000_0000_0000_0000 with NV=1, NX=0.
REQ-021 Exactly -2^63 SHALL be valid with flags 0.
REQ-022 A nonzero discarded fraction (including any nonzero subnormal) SHALL set NX=1 when NV=0.
REQ-023 ±0 SHALL give 0 with flags 0.

Reset
REQ-024 rst SHALL force state IDLE, in_ready=1, out_valid=0, out_int=0, out_flags=0 and clear all internal registers.
REQ-025 rst asserted in any state, including mid-conversion, SHALL abort the conversion with no partial result delivered.

Configuration
REQ-026 With FCVT_UNSIGNED_EN defined, the block SHALL add input is_unsigned (1 bit), captured with in_fp.
REQ-027 With is_unsigned=1, the block SHALL produce an unsigned 64-bit result.
REQ-028 With is_unsigned=1, NaN, +inf or a value ≥2^64 SHALL give 0xFFFF_FFFF_FFFF_FFFF with NV=1.
REQ-029 With is_unsigned=1, -inf or a negative value that rounds nonzero SHALL give 0 with NV=1.
REQ-030 With is_unsigned=1, a negative value that rounds to 0 SHALL give 0 with NX only.
REQ-031 Without FCVT_UNSIGNED_EN, the port SHALL be absent and the behaviour SHALL be signed only.

Structure
REQ-032 The shared package fpu_pkg SHALL hold: rm encodings, flag bit positions, EXP_BIAS=1023, double field widths, and INT64_MAX, INT64_MIN and UINT64_MAX constants.
REQ-033 The FSM state type SHALL be local to fcvt_int.
REQ-034 Rounding-increment logic (inputs rm, sign, lsb, guard, sticky; output inc) SHALL be the combinational sub-module fcvt_round_inc.

Verification
REQ-035 0x4059000000000000 (100.0), RTZ -> out_int 0x64, flags 0, out_valid exactly 3 edges after acceptance.
REQ-036 0xC004000000000000 (-2.5): RNE -> 0xFFFF_FFFF_FFFF_FFFE, NX; RMM -> -3, NX; RDN -> -3, NX; RUP -> -2, NX.
REQ-037 0x43E0000000000000 (2^63) -> 0x7FFF_FFFF_FFFF_FFFF, NV; 0xC3E0000000000000 -> 0x8000_0000_0000_0000, flags 0; 0x7FF8000000000000 -> 0x7FFF_FFFF_FFFF_FFFF, NV.
REQ-038 0x0000000000000001 (min subnormal): RUP -> 1, NX; RTZ -> 0, NX.
REQ-039 out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0; then rst pulsed during ALIGN of the next operation -> IDLE, out_valid=0, out_int=0.
REQ-040 With FCVT_UNSIGNED_EN, is_unsigned=1: 0xBFF0000000000000 (-1.0) -> 0, NV; 0xBFD0000000000000 (-0.25), RTZ -> 0, NX only.
